// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET exit sequencer: arbitrates exception, MRET and interrupts,
// issues one CSR write per cycle, then redirects fetch.
module trap_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter bit          VEC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  input  logic [XLEN-1:0] resume_pc,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            ack,
  output logic            busy,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    StIdle, StEpc, StCause, StTval, StMst, StMrst, StRedir
  } state_e;

  state_e            state_q, state_d;
  logic              is_intr_q, is_intr_d;
  logic              is_mret_q, is_mret_d;
  logic [4:0]        code_q, code_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   mstatus_q, mstatus_d;
  logic [XLEN-1:0]   mtvec_q, mtvec_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;

  logic [2:0]        pend;
  logic              irq_take;
  logic [4:0]        irq_code;
  logic [XLEN-1:0]   mst_trap, mst_mret, trap_base, trap_target;
  logic              unused_mie;

  assign pend     = {irq_meip & csr_mie[11], irq_mtip & csr_mie[7], irq_msip & csr_mie[3]};
  assign irq_take = csr_mstatus[3] & (|pend);
  // MEI > MSI > MTI
  assign irq_code = pend[2] ? 5'd11 : (pend[0] ? 5'd3 : 5'd7);

  assign unused_mie = ^{csr_mie[XLEN-1:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0]};

  always_comb begin
    mst_trap        = mstatus_q;
    mst_trap[7]     = mstatus_q[3];
    mst_trap[3]     = 1'b0;
    mst_trap[12:11] = 2'b11;
    mst_mret        = mstatus_q;
    mst_mret[3]     = mstatus_q[7];
    mst_mret[7]     = 1'b1;
    mst_mret[12:11] = 2'b11;
    trap_base       = mtvec_q & ~XLEN'(3);
    // MODE 2/3 fall through to direct
    if (VEC_EN && is_intr_q && (mtvec_q[1:0] == 2'b01)) begin
      trap_target = trap_base + XLEN'({code_q, 2'b00});
    end else begin
      trap_target = trap_base;
    end
  end

  always_comb begin
    state_d        = state_q;
    is_intr_d      = is_intr_q;
    is_mret_d      = is_mret_q;
    code_d         = code_q;
    epc_d          = epc_q;
    tval_d         = tval_q;
    mstatus_d      = mstatus_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    ack            = 1'b0;
    busy           = (state_q != StIdle);
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_q)
      StIdle: begin
        if (exc_valid || mret_valid || irq_take) begin
          ack       = 1'b1;
          mstatus_d = csr_mstatus;
          mtvec_d   = csr_mtvec;
          mepc_d    = csr_mepc;
        end
        if (exc_valid) begin
          is_intr_d = 1'b0;
          is_mret_d = 1'b0;
          code_d    = exc_cause;
          epc_d     = exc_pc;
          tval_d    = exc_tval;
          state_d   = StEpc;
        end else if (mret_valid) begin
          is_intr_d = 1'b0;
          is_mret_d = 1'b1;
          state_d   = StMrst;
        end else if (irq_take) begin
          is_intr_d = 1'b1;
          is_mret_d = 1'b0;
          code_d    = irq_code;
          epc_d     = resume_pc;
          tval_d    = '0;
          state_d   = StEpc;
        end
      end
      StEpc: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = epc_q;
        state_d   = StCause;
      end
      StCause: begin
        csr_we              = 1'b1;
        csr_waddr           = 12'h342;
        csr_wdata[XLEN-1]   = is_intr_q;
        csr_wdata[4:0]      = code_q;
        state_d             = StTval;
      end
      StTval: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h343;
        csr_wdata = tval_q;
        state_d   = StMst;
      end
      StMst: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = mst_trap;
        state_d   = StRedir;
      end
      StMrst: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = mst_mret;
        state_d   = StRedir;
      end
      StRedir: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_mret_q ? (mepc_q & ~XLEN'(3)) : trap_target;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_intr_q <= 1'b0;
      is_mret_q <= 1'b0;
      code_q    <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else begin
      state_q   <= state_d;
      is_intr_q <= is_intr_d;
      is_mret_q <= is_mret_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized events
// checked cycle-by-cycle against a per-event transaction model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid, mret_valid, irq_msip, irq_mtip, irq_meip;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, resume_pc, csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        ack, busy, csr_we, redirect_valid;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic        mret;
    logic        msip, mtip, meip;
    logic [31:0] resume, ms, mie, mtvec, mepc;
  } ev_t;

  typedef struct packed {
    logic        ack, busy, we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
  } cyc_t;

  cyc_t exp_q[$];

  trap_sequencer #(.XLEN(32), .VEC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .resume_pc(resume_pc), .csr_mstatus(csr_mstatus), .csr_mie(csr_mie),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .ack(ack), .busy(busy), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic drive(input ev_t e);
    exc_valid   = e.exc;
    exc_cause   = e.cause;
    exc_pc      = e.pc;
    exc_tval    = e.tval;
    mret_valid  = e.mret;
    irq_msip    = e.msip;
    irq_mtip    = e.mtip;
    irq_meip    = e.meip;
    resume_pc   = e.resume;
    csr_mstatus = e.ms;
    csr_mie     = e.mie;
    csr_mtvec   = e.mtvec;
    csr_mepc    = e.mepc;
  endtask

  function automatic ev_t rand_ev();
    ev_t e;
    e.exc    = ($urandom_range(0, 3) == 0);
    e.cause  = 5'($urandom_range(0, 31));
    e.pc     = $urandom;
    e.tval   = $urandom;
    e.mret   = ($urandom_range(0, 3) == 0);
    e.msip   = 1'($urandom_range(0, 1));
    e.mtip   = 1'($urandom_range(0, 1));
    e.meip   = 1'($urandom_range(0, 1));
    e.resume = $urandom;
    e.ms     = $urandom;
    e.mie    = $urandom;
    e.mtvec  = $urandom;
    e.mepc   = $urandom;
    return e;
  endfunction

  // Expected per-cycle outputs for one event presented in IDLE.
  function automatic void model(input ev_t e);
    logic [2:0]  pend;
    logic        irq;
    logic [4:0]  code;
    logic [31:0] base, tgt, mst;
    cyc_t        c;
    exp_q.delete();
    pend = {e.meip & e.mie[11], e.mtip & e.mie[7], e.msip & e.mie[3]};
    irq  = e.ms[3] && (pend != 3'b000);
    c = '0;
    if (!e.exc && !e.mret && !irq) begin
      exp_q.push_back(c);
      return;
    end
    c.ack = 1'b1;
    exp_q.push_back(c);
    c = '0;
    c.busy = 1'b1;
    c.we   = 1'b1;
    if (!e.exc && e.mret) begin
      mst = (e.ms & ~32'h1888) | 32'h1880 | (e.ms[7] ? 32'h8 : 32'h0);
      c.addr = 12'h300; c.data = mst; exp_q.push_back(c);
      c = '0; c.busy = 1'b1; c.rv = 1'b1; c.rpc = e.mepc & ~32'h3;
      exp_q.push_back(c);
      return;
    end
    if (e.exc) code = e.cause;
    else if (pend[2]) code = 5'd11;
    else if (pend[0]) code = 5'd3;
    else code = 5'd7;
    c.addr = 12'h341; c.data = e.exc ? e.pc : e.resume;           exp_q.push_back(c);
    c.addr = 12'h342; c.data = {!e.exc, 26'b0, code};              exp_q.push_back(c);
    c.addr = 12'h343; c.data = e.exc ? e.tval : 32'h0;             exp_q.push_back(c);
    mst = (e.ms & ~32'h1888) | 32'h1800 | (e.ms[3] ? 32'h80 : 32'h0);
    c.addr = 12'h300; c.data = mst;                                exp_q.push_back(c);
    base = e.mtvec & ~32'h3;
    tgt  = (!e.exc && e.mtvec[1:0] == 2'b01) ? base + 32'(code) * 4 : base;
    c = '0; c.busy = 1'b1; c.rv = 1'b1; c.rpc = tgt;
    exp_q.push_back(c);
  endfunction

  task automatic cmp_cycle(input string name, input cyc_t c);
    chk({name, ".ack"},   32'(ack),            32'(c.ack));
    chk({name, ".busy"},  32'(busy),           32'(c.busy));
    chk({name, ".we"},    32'(csr_we),         32'(c.we));
    chk({name, ".addr"},  32'(csr_waddr),      32'(c.addr));
    chk({name, ".data"},  csr_wdata,           c.data);
    chk({name, ".rv"},    32'(redirect_valid), 32'(c.rv));
    chk({name, ".rpc"},   redirect_pc,         c.rpc);
  endtask

  // Entered at posedge+1 in IDLE; noise on inputs while busy must be ignored.
  task automatic run_event(input string name, input ev_t e);
    int n;
    model(e);
    n = exp_q.size();
    drive(e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_cycle($sformatf("%s[%0d]", name, i), exp_q[i]);
      @(posedge clk);
      #1;
      if (i + 1 < n) drive(rand_ev());
      else drive('0);
    end
  endtask

  initial begin
    ev_t e;
    rst_n = 1'b0;
    drive('0);
    #12;
    cmp_cycle("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    e = '0; e.exc = 1'b1; e.cause = 5'd11; e.pc = 32'h100; e.mtvec = 32'h800; e.ms = 32'h8;
    run_event("t1_ecall", e);

    e = '0; e.meip = 1'b1; e.mie = 32'h800; e.ms = 32'h8; e.mtvec = 32'h801;
    e.resume = 32'h204;
    run_event("t2_vec_mei", e);

    e = '0; e.exc = 1'b1; e.cause = 5'd2; e.pc = 32'h440; e.tval = 32'hDEAD_BEEF;
    e.mret = 1'b1; e.mtip = 1'b1; e.mie = 32'h80; e.ms = 32'h8; e.mtvec = 32'h901;
    run_event("t3_prio", e);

    e = '0; e.mret = 1'b1; e.ms = 32'h1880; e.mepc = 32'h306;
    run_event("t4_mret", e);

    e = '0; e.meip = 1'b1; e.mie = 32'h800; e.ms = 32'h0;
    run_event("t5_masked", e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cycle("t5_quiet", '0);
      @(posedge clk);
      #1;
    end

    e = '0; e.msip = 1'b1; e.mtip = 1'b1; e.mie = 32'h88; e.ms = 32'h8; e.mtvec = 32'h1001;
    e.resume = 32'h5550;
    run_event("t_msi_over_mti", e);

    // Reset mid-sequence while in the mtval write cycle
    e = '0; e.exc = 1'b1; e.cause = 5'd5; e.pc = 32'h700; e.tval = 32'h1234; e.ms = 32'h8;
    drive(e);
    @(negedge clk);
    chk("t6_ack", 32'(ack), 32'd1);
    @(posedge clk); #1; drive('0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_in_tval", 32'(csr_waddr), 32'h343);
    rst_n = 1'b0;
    #1;
    cmp_cycle("t6_reset_now", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp_cycle("t6_after", '0);
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 80; k++) begin
      run_event($sformatf("rnd%0d", k), rand_ev());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
